// File: rtl/fsm_seq_ctrl.sv
// fsm_seq_ctrl: sequencing controller for a 4-state Moore pattern FSM.
// Accepts a WIDTH-bit stimulus word and clears the FSM through its reset.
// It then shifts the word into the FSM LSB first and collects the FSM output
// after every bit into a WIDTH-bit result word.
// The result word is returned over a valid/ready handshake.
module fsm_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    input  logic [WIDTH-1:0] start_data,
    output logic             start_ready,
    output logic             fsm_reset_n,
    output logic             fsm_din,
    input  logic             fsm_dout,
    output logic             result_valid,
    output logic [WIDTH-1:0] result_data,
    input  logic             result_ready,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] result_q;
    logic             fsm_rst_q;
    logic             accept;

    assign accept = (state == IDLE) && start_valid;

    // Next-state selection for the sequencing FSM
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_valid) state_nxt = CLEAR;
            CLEAR:   state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == LAST_BIT) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    if (result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Bit counter: restarts on accept, advances once per SHIFT cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                bit_cnt <= '0;
        else if (accept)           bit_cnt <= '0;
        else if (state == SHIFT)   bit_cnt <= bit_cnt + CNT_W'(1);
    end

    // FSM reset is registered from the next state so it cannot glitch;
    // it is low exactly for the CLEAR cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fsm_rst_q <= 1'b0;
        else        fsm_rst_q <= (state_nxt != CLEAR);
    end

    // Stimulus shift register: loaded on accept, shifted right with 0 fill
    always_ff @(posedge clk) begin
        if (accept)              shreg <= start_data;
        else if (state == SHIFT) shreg <= shreg >> 1;
    end

    // Result capture: the Moore output shows the effect of a bit one cycle
    // after that bit is driven, so each sample lands in the previous bit slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
        end else if (accept) begin
            result_q <= '0;
        end else if (state == SHIFT && bit_cnt != '0) begin
            result_q[bit_cnt - CNT_W'(1)] <= fsm_dout;
        end else if (state == DRAIN) begin
            result_q[WIDTH-1] <= fsm_dout;
        end
    end

    assign start_ready  = (state == IDLE);
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);
    assign result_data  = result_q;
    assign fsm_reset_n  = fsm_rst_q;
    assign fsm_din      = (state == SHIFT) & shreg[0];

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Testbench for fsm_seq_ctrl: a behavioural pattern FSM drives fsm_dout.
// A job-level reference model predicts every controller output each cycle.
// Directed jobs pin results and latencies to hand-computed values.
module tb_fsm_seq_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start_valid;
    logic [W-1:0] start_data;
    logic         start_ready;
    logic         fsm_reset_n;
    logic         fsm_din;
    logic         fsm_dout;
    logic         result_valid;
    logic [W-1:0] result_data;
    logic         result_ready;
    logic         busy;

    logic         sv2, sr2, frn2, fdi2, fdo2, rv2, rr2, busy2;
    logic [1:0]   sd2, rd2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    fsm_seq_ctrl #(.WIDTH(W)) u_dut (
        .clk(clk), .reset(reset),
        .start_valid(start_valid), .start_data(start_data), .start_ready(start_ready),
        .fsm_reset_n(fsm_reset_n), .fsm_din(fsm_din), .fsm_dout(fsm_dout),
        .result_valid(result_valid), .result_data(result_data), .result_ready(result_ready),
        .busy(busy)
    );

    fsm_seq_ctrl #(.WIDTH(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .start_valid(sv2), .start_data(sd2), .start_ready(sr2),
        .fsm_reset_n(frn2), .fsm_din(fdi2), .fsm_dout(fdo2),
        .result_valid(rv2), .result_data(rd2), .result_ready(rr2),
        .busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Pattern FSM transition table and Moore outputs (S0=1, S1=0, S2=0, S3=1)
    function automatic logic [1:0] tr(input logic [1:0] s, input logic b);
        case (s)
            2'd0:    return b ? 2'd1 : 2'd0;
            2'd1:    return b ? 2'd1 : 2'd2;
            2'd2:    return b ? 2'd3 : 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic outp(input logic [1:0] s);
        return (s == 2'd0) || (s == 2'd3);
    endfunction

    // Expected result word: run the pattern FSM from State0 over the word
    function automatic logic [W-1:0] expect_word(input logic [W-1:0] w);
        logic [1:0]   s;
        logic [W-1:0] r;
        s = 2'd0;
        r = '0;
        for (int i = 0; i < W; i++) begin
            s = tr(s, w[i]);
            r[i] = outp(s);
        end
        return r;
    endfunction

    // Environment FSM instances attached to each controller
    logic [1:0] env_st  = 2'd0;
    logic [1:0] env_st2 = 2'd0;
    always @(posedge clk or negedge fsm_reset_n)
        if (!fsm_reset_n) env_st <= 2'd0;
        else              env_st <= tr(env_st, fsm_din);
    always @(posedge clk or negedge frn2)
        if (!frn2) env_st2 <= 2'd0;
        else       env_st2 <= tr(env_st2, fdi2);
    assign fsm_dout = outp(env_st);
    assign fdo2     = outp(env_st2);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Job-level model: phase -1 idle, 0 clear, 1..W bit phase-1 driven,
    // W+1 drain, W+2 result held
    int           m_phase = -1;
    logic         m_pend  = 1'b1;
    logic [W-1:0] m_word  = '0;
    logic [W-1:0] m_last  = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase <= -1;
            m_pend  <= 1'b1;
            m_last  <= '0;
        end else begin
            m_pend <= 1'b0;
            if (m_phase == -1) begin
                if (start_valid) begin
                    m_phase <= 0;
                    m_word  <= start_data;
                end
            end else if (m_phase == W + 2) begin
                if (result_ready) m_phase <= -1;
            end else begin
                m_phase <= m_phase + 1;
                if (m_phase == W + 1) m_last <= expect_word(m_word);
            end
        end
    end

    // Per-cycle comparison of every controller output against the model
    always @(negedge clk) begin
        chk("start_ready", 32'(start_ready), 32'(m_phase == -1));
        chk("busy", 32'(busy), 32'(m_phase != -1));
        chk("result_valid", 32'(result_valid), 32'(m_phase == W + 2));
        chk("fsm_reset_n", 32'(fsm_reset_n), 32'(!(m_pend || m_phase == 0)));
        chk("fsm_din", 32'(fsm_din),
            32'((m_phase >= 1 && m_phase <= W) ? m_word[m_phase-1] : 1'b0));
        if (m_phase == -1 || m_phase == W + 2)
            chk("result_data", 32'(result_data), 32'(m_last));
    end

    // Runs one job starting at posedge+1; optionally holds back-pressure
    task automatic do_job(input logic [W-1:0] w, input int hold,
                          output logic [W-1:0] res, output int acc_e,
                          output int vld_e, output int pop_e);
        int n;
        n = 0;
        while (!start_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        start_valid = 1'b1;
        start_data  = w;
        @(posedge clk); #1;
        acc_e = cyc;
        start_valid = 1'b0;
        n = 0;
        while (!result_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!result_valid) chk("valid_timeout", 32'(result_valid), 32'd1);
        vld_e = cyc;
        res   = result_data;
        if (hold > 0) begin
            result_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                start_valid = 1'($urandom_range(0, 1));
                start_data  = W'($urandom);
                @(posedge clk); #1;
                chk("hold_data", 32'(result_data), 32'(res));
                chk("hold_start_ready", 32'(start_ready), 32'd0);
            end
            start_valid  = 1'b0;
            result_ready = 1'b1;
        end
        @(posedge clk); #1;
        pop_e = cyc;
    endtask

    logic [W-1:0] res;
    int acc_e, vld_e, pop_e, prev_acc, n2, acc2;
    logic [W-1:0] words [4] = '{8'h05, 8'h00, 8'hFF, 8'h0F};
    logic [W-1:0] golds [4] = '{8'hFC, 8'hFF, 8'h00, 8'h00};

    initial begin
        reset = 1'b1; start_valid = 1'b0; start_data = '0; result_ready = 1'b1;
        sv2 = 1'b0; sd2 = '0; rr2 = 1'b0;
        #1 reset = 1'b0;
        #2;
        chk("rst_start_ready", 32'(start_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_result_data", 32'(result_data), 32'd0);
        chk("rst_fsm_din", 32'(fsm_din), 32'd0);
        chk("rst_fsm_reset_n", 32'(fsm_reset_n), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("fsm_reset_n_after_edge", 32'(fsm_reset_n), 32'd1);

        // Basic job
        do_job(8'h2D, 0, res, acc_e, vld_e, pop_e);
        chk("res_2D", 32'(res), 32'h1C);
        chk("latency_2D", 32'(vld_e - acc_e), 32'd10);

        // Back-to-back with result_ready held high
        prev_acc = -1;
        for (int i = 0; i < 4; i++) begin
            do_job(words[i], 0, res, acc_e, vld_e, pop_e);
            chk("res_b2b", 32'(res), 32'(golds[i]));
            if (prev_acc >= 0) chk("accept_spacing", 32'(acc_e - prev_acc), 32'd12);
            prev_acc = acc_e;
        end

        // FSM left in State3, then words that depend on the clear
        do_job(8'h82, 0, res, acc_e, vld_e, pop_e);
        chk("res_82", 32'(res), 32'h81);
        do_job(8'h00, 0, res, acc_e, vld_e, pop_e);
        chk("res_00_after_s3", 32'(res), 32'hFF);
        do_job(8'h82, 0, res, acc_e, vld_e, pop_e);
        do_job(8'h01, 0, res, acc_e, vld_e, pop_e);
        chk("res_01_after_s3", 32'(res), 32'h00);

        // Back-pressure hold of 20 cycles, then accept on the following cycle
        do_job(8'h2D, 20, res, acc_e, vld_e, pop_e);
        chk("res_hold", 32'(res), 32'h1C);
        chk("post_pop_result_data", 32'(result_data), 32'h1C);
        do_job(8'h05, 0, res, acc_e, vld_e, pop_e);
        chk("accept_after_pop", 32'(acc_e - (vld_e - 10 - 1)), 32'd1);
        chk("res_05_after_hold", 32'(res), 32'hFC);

        // Reset during SHIFT bit 4
        start_valid = 1'b1; start_data = 8'h2D;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("midshift_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_start_ready", 32'(start_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result_valid", 32'(result_valid), 32'd0);
        chk("abort_result_data", 32'(result_data), 32'd0);
        chk("abort_fsm_din", 32'(fsm_din), 32'd0);
        chk("abort_fsm_reset_n", 32'(fsm_reset_n), 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        chk("no_valid_after_abort", 32'(result_valid), 32'd0);
        do_job(8'h2D, 0, res, acc_e, vld_e, pop_e);
        chk("res_2D_after_abort", 32'(res), 32'h1C);

        // WIDTH=2 instance
        sv2 = 1'b1; sd2 = 2'b01;
        @(posedge clk); #1;
        acc2 = cyc;
        sv2 = 1'b0;
        n2 = 0;
        while (!rv2 && n2 < 50) begin @(posedge clk); #1; n2++; end
        chk("w2_valid", 32'(rv2), 32'd1);
        chk("w2_latency", 32'(cyc - acc2), 32'd4);
        chk("w2_result", 32'(rd2), 32'd0);
        chk("w2_busy", 32'(busy2), 32'd1);
        rr2 = 1'b1;
        @(posedge clk); #1;
        chk("w2_popped", 32'(rv2), 32'd0);
        chk("w2_start_ready", 32'(sr2), 32'd1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_seq_ctrl.md
# fsm_seq_ctrl

Sequencing controller for the 4-state Moore pattern FSM (State0..State3; outputs 1,0,0,1). It accepts a parallel WIDTH-bit stimulus word over a valid/ready handshake and clears the FSM through its active-low reset. It then shifts the word into the FSM's data_in one bit per cycle, LSB first, and captures the FSM's data_out after every bit into a WIDTH-bit result word. The result is returned over a second valid/ready handshake. The block sits between a host/test sequencer and one FSM instance, and owns that instance's reset and data_in.

## Interface
- WIDTH, 8, stimulus/result word width; legal range 2..32.
- clk  input  1  single clock; all flops rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start_valid  input  1  stimulus word offered.
- start_data  input  WIDTH  stimulus word; bit 0 is shifted first.
- start_ready  output  1  high only in IDLE; a word is accepted when start_valid && start_ready at a clk edge.
- fsm_reset_n  output  1  drives the FSM reset; registered, glitch-free.
- fsm_din  output  1  drives the FSM data_in.
- fsm_dout  input  1  FSM data_out (Moore; reflects the state after the last clk edge).
- result_valid  output  1  result word available; held until taken.
- result_data  output  WIDTH  bit i = FSM output after consuming stimulus bits 0..i.
- result_ready  input  1  consumer accepts; pop occurs when result_valid && result_ready at a clk edge.
- busy  output  1  high in every state except IDLE.

## Operation
- States and transitions:
  - IDLE: go to CLEAR on accept; otherwise stay.
  - CLEAR: exactly 1 cycle; go to SHIFT.
  - SHIFT: WIDTH cycles, counted by a bit counter 0..WIDTH-1; go to DRAIN when count = WIDTH-1.
  - DRAIN: exactly 1 cycle; go to DONE.
  - DONE: go to IDLE on pop; otherwise stay.
- On accept, start_data is loaded into the shift register, and the bit counter and result register are cleared.
- CLEAR: fsm_reset_n = 0 for the whole cycle, which forces the FSM to State0.
- fsm_reset_n = 1 in IDLE, SHIFT, DRAIN and DONE.
- SHIFT cycle k (k = 0..WIDTH-1): fsm_din = shift register bit 0; the shift register shifts right with 0 fill at each edge.
- In SHIFT cycle k ≥ 1 and in DRAIN, fsm_dout is sampled at the edge ending the cycle into result bit k-1 (bit WIDTH-1 in DRAIN). This is one-cycle sample lag, because a Moore output reflects a bit only after the edge that consumes it.
- fsm_din = 0 in IDLE, CLEAR, DRAIN and DONE.
- result_data is stable for the whole time result_valid is high; it keeps its last value after the pop until the next accept.
- start_data and start_valid are ignored outside IDLE. result_ready is ignored outside DONE.
- No accept occurs in the same cycle as a pop. The earliest next accept is the cycle after the DONE→IDLE edge.

## Timing
- Reset values (asynchronous): state = IDLE; start_ready = 1; busy = 0; result_valid = 0; result_data = 0; fsm_din = 0; fsm_reset_n = 0.
- fsm_reset_n goes low asynchronously with reset (the FSM is held in reset with the controller) and returns to 1 at the first clk edge after reset deasserts.
- Latency: with accept at edge E, result_valid rises at edge E+WIDTH+2 (10 edges for WIDTH=8).
- Throughput: one word per WIDTH+4 cycles minimum when result_ready is held high.
- busy and start_ready are decoded from state registers; they are never combinational from inputs.
- Reset mid-operation (any state): all outputs return to reset values immediately, and any partial result is discarded. No result_valid is produced for the aborted word.
- Back-pressure: a DONE hold of any length does not disturb result_data, fsm_din or fsm_reset_n.

## Test plan
- Reset, then hold: all outputs equal their reset values; start_ready = 1, fsm_reset_n = 1 after the first edge. Drive start_data=8'h2D (FSM path S1,S2,S3,S0,S0,S1,S2,S2) -> result_data=8'h1C, with result_valid rising exactly 10 edges after accept.
- Words 8'h05, 8'h00, 8'hFF, 8'h0F back-to-back with result_ready=1 -> results 8'hFC, 8'hFF, 8'h00, 8'h00. Each accept occurs 12 edges after the previous one.
- Previous job leaves the FSM in State3; the next word is 8'h00 -> result 8'hFF, which proves CLEAR pulsed fsm_reset_n low for exactly 1 cycle before the first bit.
- Hold result_ready=0 for 20 cycles in DONE while toggling start_valid/start_data -> result_data stable, start_ready=0, no accept; pop, then accept on the following cycle.
- Assert reset during SHIFT bit 4 -> immediate return to reset values with fsm_reset_n=0. After release, a new word 8'h2D still yields 8'h1C.
- WIDTH=2 build: start_data=2'b01 -> result 2'b00, with result_valid 4 edges after accept.
